// File: rtl/apb_ctrl_pkg.sv
// apb_ctrl_pkg: shared state encoding, default widths and slave-index legality check
package apb_ctrl_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_e;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_SEL_W  = 1;

    function automatic logic idx_legal(input int unsigned idx, input int unsigned num);
        return idx < num;
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: saturating count of ACCESS wait cycles, flags the cycle that reaches TIMEOUT
module apb_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam int W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [W-1:0] LIM = W'(TIMEOUT);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clear ? '0 : (count_en && cnt_q != LIM) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // the wait cycle being counted now is the TIMEOUT-th one
    assign expired = (TIMEOUT > 0) && count_en && (cnt_q == LIM - 1'b1);

endmodule

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: valid/ready requester to APB bridge with slave decode, wait-state timeout and response strobe
module apb_master_ctrl
    import apb_ctrl_pkg::*;
#(
    parameter int NUM_SLAVES = 2,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SEL_W      = DEF_SEL_W,
    parameter int TIMEOUT    = 15
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [SEL_W+ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]            req_wdata,
    output logic                         rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err,
    output logic [NUM_SLAVES-1:0]        PSEL,
    output logic                         PENABLE,
    output logic                         PWRITE,
    output logic [ADDR_W-1:0]            PADDR,
    output logic [DATA_W-1:0]            PWDATA,
    input  logic [NUM_SLAVES-1:0]        PREADY,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA
);
    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                pwrite_q, pwrite_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                err_pend_q, err_pend_d;
    logic [SEL_W-1:0]    req_idx;
    logic                legal, pready_sel, timed_out, complete, accept, go_setup, bad;
    logic [DATA_W-1:0]   prdata_sel;

    assign req_idx    = req_addr[SEL_W+ADDR_W-1:ADDR_W];
    assign legal      = idx_legal(32'(req_idx), 32'(NUM_SLAVES));
    assign pready_sel = PREADY[sel_q];
    assign prdata_sel = PRDATA[sel_q*DATA_W +: DATA_W];
    assign complete   = (state_q == ST_ACCESS) && (pready_sel || timed_out);
    // an illegal index taken on a completing cycle answers one cycle late, so IDLE holds off for that cycle
    assign req_ready  = (state_q == ST_IDLE) ? !err_pend_q : complete;
    assign accept     = req_valid && req_ready;
    assign go_setup   = accept && legal;
    assign bad        = accept && !legal;

    apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (PCLK),
        .rst     (PRESET),
        .clear   (go_setup),
        .count_en((state_q == ST_ACCESS) && !pready_sel),
        .expired (timed_out)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            err_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_pend_q  <= err_pend_d;
        end
    end

    always_comb begin
        state_d = (state_q == ST_SETUP) ? ST_ACCESS :
                  go_setup ? ST_SETUP :
                  (state_q == ST_ACCESS && !complete) ? ST_ACCESS : ST_IDLE;
    end

    always_comb begin
        sel_d       = go_setup ? req_idx : sel_q;
        paddr_d     = go_setup ? req_addr[ADDR_W-1:0] : paddr_q;
        pwdata_d    = go_setup ? req_wdata : pwdata_q;
        pwrite_d    = go_setup ? req_write : pwrite_q;
        rsp_valid_d = complete || (bad && state_q == ST_IDLE) || err_pend_q;
        rsp_err_d   = (complete && !pready_sel) || (bad && state_q == ST_IDLE) || err_pend_q;
        rsp_rdata_d = (complete && pready_sel && !pwrite_q) ? prdata_sel : '0;
        err_pend_d  = bad && (state_q == ST_ACCESS);
        PSEL        = (state_q != ST_IDLE) ? NUM_SLAVES'(1) << sel_q : '0;
        PENABLE     = state_q == ST_ACCESS;
    end

    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PWRITE    = pwrite_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl: directed scenarios plus random traffic against a transaction-timeline model with stub slaves
module tb_apb_master_ctrl;
    localparam int NS = 3, AW = 8, DW = 8, SW = 2, TO = 4, MAXC = 4096;

    logic PCLK = 1'b0, PRESET = 1'b0;
    logic req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [SW+AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0, rsp_rdata, PWDATA;
    logic rsp_valid, rsp_err, PENABLE, PWRITE;
    logic [NS-1:0] PSEL, PREADY = '0;
    logic [AW-1:0] PADDR;
    logic [NS*DW-1:0] PRDATA = '0;

    apb_master_ctrl #(.NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY(PREADY), .PRDATA(PRDATA)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0, failures = 0;
    int cyc, a, xlen, w, msel, stall_cyc;
    bit busy, m_pwrite;
    logic [AW-1:0] m_paddr;
    logic [DW-1:0] m_pwdata;
    logic [DW-1:0] mem [NS][256];
    bit ev [MAXC];
    bit eerr [MAXC];
    logic [DW-1:0] erd [MAXC];
    logic [NS-1:0] o_psel [MAXC];
    bit o_pen [MAXC];
    bit o_rv [MAXC];
    bit o_err [MAXC];
    logic [DW-1:0] o_rd [MAXC];
    bit drv_valid, drv_write;
    logic [SW+AW-1:0] drv_addr;
    logic [DW-1:0] drv_wdata;
    int nxt_w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        busy = 0; cyc = 0; stall_cyc = -1; a = 0; xlen = 0; w = 0; msel = 0;
        m_paddr = '0; m_pwdata = '0; m_pwrite = 0;
        for (int i = 0; i < MAXC; i++) begin ev[i] = 0; eerr[i] = 0; erd[i] = '0; end
    endtask

    // One bus cycle: drive, compare everything against the timeline model, then advance it
    task automatic step(output bit acc);
        bit setup_ph, acc_ph, comp, erdy;
        int k;
        logic [SW-1:0] idx;
        logic [NS-1:0] epsel;
        @(negedge PCLK);
        req_valid = drv_valid; req_write = drv_write; req_addr = drv_addr; req_wdata = drv_wdata;
        setup_ph = busy && cyc == a + 1;
        acc_ph   = busy && cyc >= a + 2 && cyc <= a + 1 + xlen;
        comp     = busy && cyc == a + 1 + xlen;
        k        = cyc - a - 2;
        PREADY = NS'($urandom);
        PRDATA = (NS*DW)'($urandom);
        if (acc_ph) begin
            PREADY[msel] = (k == w);
            if (k == w) PRDATA[msel*DW +: DW] = mem[msel][m_paddr];
        end
        #1;
        erdy  = (!busy || comp) && cyc != stall_cyc;
        epsel = (setup_ph || acc_ph) ? NS'(1) << msel : '0;
        chk("req_ready", 32'(req_ready), 32'(erdy));
        chk("psel", 32'(PSEL), 32'(epsel));
        chk("penable", 32'(PENABLE), 32'(acc_ph));
        chk("paddr", 32'(PADDR), 32'(m_paddr));
        chk("pwdata", 32'(PWDATA), 32'(m_pwdata));
        chk("pwrite", 32'(PWRITE), 32'(m_pwrite));
        chk("rsp_valid", 32'(rsp_valid), 32'(ev[cyc]));
        if (ev[cyc]) begin
            chk("rsp_err", 32'(rsp_err), 32'(eerr[cyc]));
            chk("rsp_rdata", 32'(rsp_rdata), 32'(erd[cyc]));
        end
        o_psel[cyc] = PSEL; o_pen[cyc] = PENABLE; o_rv[cyc] = rsp_valid;
        o_err[cyc] = rsp_err; o_rd[cyc] = rsp_rdata;
        acc = drv_valid && erdy;
        if (comp) begin
            ev[cyc+1]   = 1;
            eerr[cyc+1] = w >= TO;
            erd[cyc+1]  = (m_pwrite || w >= TO) ? '0 : mem[msel][m_paddr];
            if (m_pwrite && w < TO) mem[msel][m_paddr] = m_pwdata;
            busy = 0;
        end
        if (acc) begin
            idx = drv_addr[SW+AW-1:AW];
            if (int'(idx) < NS) begin
                busy = 1; a = cyc; msel = int'(idx);
                m_paddr = drv_addr[AW-1:0]; m_pwdata = drv_wdata; m_pwrite = drv_write;
                w = nxt_w; xlen = (w + 1 < TO) ? w + 1 : TO;
            end else begin
                ev[cyc+1+int'(comp)] = 1; eerr[cyc+1+int'(comp)] = 1; erd[cyc+1+int'(comp)] = '0;
                if (comp) stall_cyc = cyc + 1;
            end
        end
        cyc++;
    endtask

    task automatic req(input logic [SW+AW-1:0] ad, input bit wr, input logic [DW-1:0] d,
                       input int wt, output int ac);
        bit got;
        drv_valid = 1; drv_addr = ad; drv_write = wr; drv_wdata = d; nxt_w = wt; ac = -1;
        for (int i = 0; i < 20 && ac < 0; i++) begin
            step(got);
            if (got) ac = cyc - 1;
        end
        drv_valid = 0;
        chk("req_accepted", 32'(ac >= 0), 32'd1);
        if (ac < 0) ac = 0;
    endtask

    task automatic idle(input int n);
        bit got;
        drv_valid = 0;
        for (int i = 0; i < n; i++) step(got);
    endtask

    task automatic do_reset(input bit busy_now);
        @(negedge PCLK);
        drv_valid = 0; req_valid = 0; PREADY = '0;
        #1;
        if (busy_now) chk("pre_reset_penable", 32'(PENABLE), 32'd1);
        PRESET = 1;
        #1;
        chk("rst_psel", 32'(PSEL), 0);
        chk("rst_penable", 32'(PENABLE), 0);
        chk("rst_paddr", 32'(PADDR), 0);
        chk("rst_pwdata", 32'(PWDATA), 0);
        chk("rst_pwrite", 32'(PWRITE), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_req_ready", 32'(req_ready), 1);
        @(negedge PCLK);
        PRESET = 0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, m, c0, c1;
        bit got;
        logic [1:0] ri;
        for (int s = 0; s < NS; s++) for (int i = 0; i < 256; i++) mem[s][i] = DW'($urandom);
        drv_valid = 0; drv_write = 0; drv_addr = '0; drv_wdata = '0; nxt_w = 0;
        model_reset();
        #1 PRESET = 1;
        do_reset(0);

        // zero-wait write then read on slave 0
        req(10'h010, 1, 8'hA5, 0, n); idle(4);
        chk("t2_psel_setup", 32'(o_psel[n+1]), 32'b001);
        chk("t2_psel_access", 32'(o_psel[n+2]), 32'b001);
        chk("t2_pen_setup", 32'(o_pen[n+1]), 0);
        chk("t2_pen_access", 32'(o_pen[n+2]), 1);
        chk("t2_rv_early", 32'(o_rv[n+2]), 0);
        chk("t2_rv_n3", 32'(o_rv[n+3]), 1);
        chk("t2_err", 32'(o_err[n+3]), 0);
        req(10'h010, 0, 8'h00, 0, n); idle(4);
        chk("t2_rdata", 32'(o_rd[n+3]), 32'hA5);

        // back-to-back writes with valid held
        req(10'h120, 1, 8'h3C, 0, n); req(10'h121, 1, 8'h5A, 0, m); idle(4);
        chk("t3_gap", 32'(m - n), 2);
        chk("t3_second_setup_pen", 32'(o_pen[n+3]), 0);
        chk("t3_second_setup_psel", 32'(o_psel[n+3]), 32'b010);
        chk("t3_rv1", 32'(o_rv[n+3]), 1);
        chk("t3_rv2", 32'(o_rv[m+3]), 1);
        req(10'h120, 0, 8'h00, 0, n); idle(4);
        chk("t3_rd0", 32'(o_rd[n+3]), 32'h3C);
        req(10'h121, 0, 8'h00, 0, n); idle(4);
        chk("t3_rd1", 32'(o_rd[n+3]), 32'h5A);

        // three wait states on slave 1
        req(10'h155, 1, 8'h77, 3, n); idle(8);
        c0 = 0; c1 = 0;
        for (int i = n + 1; i <= n + 8; i++) begin c0 += int'(o_pen[i]); c1 += int'(o_rv[i]); end
        chk("t4_pen_cycles", 32'(c0), 4);
        chk("t4_rv_count", 32'(c1), 1);
        chk("t4_rv_at", 32'(o_rv[n+6]), 1);
        chk("t4_err", 32'(o_err[n+6]), 0);

        // slave 2 never ready -> timeout
        req(10'h205, 0, 8'h00, 9, n); idle(8);
        c0 = 0;
        for (int i = n + 1; i <= n + 8; i++) c0 += int'(o_pen[i]);
        chk("t5_pen_cycles", 32'(c0), 4);
        chk("t5_rv", 32'(o_rv[n+6]), 1);
        chk("t5_err", 32'(o_err[n+6]), 1);
        chk("t5_rdata", 32'(o_rd[n+6]), 0);
        chk("t5_bus_released", 32'(o_psel[n+6]), 0);

        // decode error on index 3
        req(10'h3AA, 1, 8'h11, 0, n); idle(3);
        c0 = 0;
        for (int i = n; i <= n + 3; i++) c0 += int'(o_psel[i] != '0);
        chk("t6_no_psel", 32'(c0), 0);
        chk("t6_rv", 32'(o_rv[n+1]), 1);
        chk("t6_err", 32'(o_err[n+1]), 1);
        chk("t6_rdata", 32'(o_rd[n+1]), 0);

        // reset during a wait state drops the transfer, next request runs normally
        req(10'h101, 1, 8'h44, 0, n); idle(4);
        req(10'h101, 1, 8'hEE, 9, n);
        for (int i = 0; i < 3; i++) step(got);
        do_reset(1);
        idle(8);
        req(10'h101, 0, 8'h00, 0, n); idle(4);
        chk("t1_rv", 32'(o_rv[n+3]), 1);
        chk("t1_rdata_kept", 32'(o_rd[n+3]), 32'h44);

        // random traffic
        for (int t = 0; t < 1500; t++) begin
            drv_valid = $urandom_range(0, 3) != 0;
            ri = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            drv_addr = {ri, 8'($urandom_range(0, 7))};
            drv_write = 1'($urandom_range(0, 1));
            drv_wdata = DW'($urandom);
            nxt_w = $urandom_range(0, 5);
            step(got);
        end
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
